// File: rtl/convertidor_bin_bcd_pkg.sv
// Shared constants and state encoding for the display path
// (binary-to-BCD converter feeding the 7-segment controller).
package paquete_display;
  localparam int ANCHO_BIN   = 14;
  localparam int NUM_DIGITOS = 4;
  localparam int ANCHO_BCD   = 4 * NUM_DIGITOS;
  localparam int ANCHO_REG   = ANCHO_BCD + ANCHO_BIN;
  localparam logic [ANCHO_BIN-1:0] VALOR_MAX = 14'd9999;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    DESPLAZA = 2'd1,
    LISTO    = 2'd2
  } estado_t;

  // Clamp to the largest value four decimal digits can show
  function automatic logic [ANCHO_BIN-1:0] saturar(input logic [ANCHO_BIN-1:0] v,
                                                   input logic [ANCHO_BIN-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction
endpackage

// File: rtl/convertidor_bin_bcd_if.sv
// Request/result bundle between a producer of binary values and the
// converter; the digit outputs go straight to the display controller.
interface convertidor_bin_bcd_if;
  import paquete_display::*;
  logic                 i_Start;
  logic [ANCHO_BIN-1:0] i_Binario;
  logic                 o_Ocupado;
  logic                 o_Listo;
  logic                 o_Desborde;
  logic [3:0]           o_Datos_1;
  logic [3:0]           o_Datos_2;
  logic [3:0]           o_Datos_3;
  logic [3:0]           o_Datos_4;

  modport master (
    output i_Start, i_Binario,
    input  o_Ocupado, o_Listo, o_Desborde,
           o_Datos_1, o_Datos_2, o_Datos_3, o_Datos_4
  );

  modport slave (
    input  i_Start, i_Binario,
    output o_Ocupado, o_Listo, o_Desborde,
           o_Datos_1, o_Datos_2, o_Datos_3, o_Datos_4
  );
endinterface

// File: rtl/convertidor_bin_bcd_ajuste.sv
// Double-dabble digit correction: a nibble >= 5 gets +3 so the next
// left shift carries correctly into the following decimal digit.
module ajuste_bcd_nibble (
  input  logic [3:0] i_Nibble,
  output logic [3:0] o_Nibble
);
  assign o_Nibble = (i_Nibble >= 4'd5) ? i_Nibble + 4'd3 : i_Nibble;
endmodule

// File: rtl/convertidor_bin_bcd.sv
// Sequential binary-to-BCD converter, one shift-add-3 iteration per clock.
// Digits are only updated when a conversion completes.
module convertidor_bin_bcd
  import paquete_display::*;
#(
  parameter int                   P_ANCHO_BIN = ANCHO_BIN,
  parameter logic [ANCHO_BIN-1:0] P_VALOR_MAX = VALOR_MAX
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  convertidor_bin_bcd_if.slave   bus
);
  localparam logic [3:0] ULTIMA = 4'(P_ANCHO_BIN - 1);

  estado_t                estado, estado_sig;
  logic [3:0]             cnt;
  logic [ANCHO_REG-1:0]   sr;
  logic [ANCHO_REG-1:0]   sr_aj;
  logic [ANCHO_REG-1:0]   sr_desp;
  logic [ANCHO_BCD-1:0]   bcd_aj;
  logic [ANCHO_BCD-1:0]   digitos;
  logic                   desborde;
  logic                   carga, desplaza, fin;

  // Nibbles are corrected independently, then the whole register shifts
  for (genvar g = 0; g < NUM_DIGITOS; g++) begin : g_nib
    ajuste_bcd_nibble u_aj (
      .i_Nibble (sr[ANCHO_BIN + 4*g +: 4]),
      .o_Nibble (bcd_aj[4*g +: 4])
    );
  end

  assign sr_aj   = {bcd_aj, sr[ANCHO_BIN-1:0]};
  assign sr_desp = sr_aj << 1;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) estado <= REPOSO;
    else       estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    carga      = 1'b0;
    desplaza   = 1'b0;
    fin        = 1'b0;
    case (estado)
      REPOSO: begin
        if (bus.i_Start) begin
          estado_sig = DESPLAZA;
          carga      = 1'b1;
        end
      end
      DESPLAZA: begin
        desplaza = 1'b1;
        if (cnt == ULTIMA) begin
          estado_sig = LISTO;
          fin        = 1'b1;
        end
      end
      LISTO: begin
        if (bus.i_Start) begin
          estado_sig = DESPLAZA;
          carga      = 1'b1;
        end else begin
          estado_sig = REPOSO;
        end
      end
      default: estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sr       <= '0;
      cnt      <= '0;
      desborde <= 1'b0;
      digitos  <= '0;
    end else if (carga) begin
      sr       <= {{ANCHO_BCD{1'b0}}, saturar(bus.i_Binario, P_VALOR_MAX)};
      cnt      <= '0;
      desborde <= (bus.i_Binario > P_VALOR_MAX);
    end else if (desplaza) begin
      sr  <= sr_desp;
      cnt <= cnt + 4'd1;
      // The last shift's BCD field is the final result
      if (fin) digitos <= sr_desp[ANCHO_REG-1 -: ANCHO_BCD];
    end
  end

  assign bus.o_Ocupado  = (estado == DESPLAZA);
  assign bus.o_Listo    = (estado == LISTO);
  assign bus.o_Desborde = desborde;
  assign bus.o_Datos_1  = digitos[15:12];
  assign bus.o_Datos_2  = digitos[11:8];
  assign bus.o_Datos_3  = digitos[7:4];
  assign bus.o_Datos_4  = digitos[3:0];
endmodule

// File: tb/tb_convertidor_bin_bcd.sv
// Directed plus randomized bench for convertidor_bin_bcd; expected digits
// come from decimal arithmetic on the saturated input value.
module tb_convertidor_bin_bcd;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  convertidor_bin_bcd_if bus();
  convertidor_bin_bcd dut (.i_Clk(clk), .i_Rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;
  logic [15:0] esp_dig;
  logic        esp_desb;
  logic [15:0] digitos;
  assign digitos = {bus.o_Datos_1, bus.o_Datos_2, bus.o_Datos_3, bus.o_Datos_4};

  function automatic logic [15:0] modelo(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One conversion; optionally pulse a second start at busy cycle glitch_at
  task automatic convertir(input int v, input int glitch_at, input int vg);
    int n;
    @(negedge clk);
    bus.i_Start   = 1'b1;
    bus.i_Binario = 14'(v);
    @(negedge clk);
    bus.i_Start   = 1'b0;
    bus.i_Binario = 14'($urandom);
    n = 1;
    while (!bus.o_Listo && n < 40) begin
      chk("ocupado", 32'(bus.o_Ocupado), 32'd1);
      chk("retencion", 32'(digitos), 32'(esp_dig));
      if (n == glitch_at) begin
        bus.i_Start   = 1'b1;
        bus.i_Binario = 14'(vg);
      end else begin
        bus.i_Start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.i_Start = 1'b0;
    esp_dig  = modelo(v);
    esp_desb = (v > 9999);
    chk("latencia", 32'(n - 1), 32'd14);
    chk("digitos", 32'(digitos), 32'(esp_dig));
    chk("desborde", 32'(bus.o_Desborde), 32'(esp_desb));
    chk("ocupado_listo", 32'(bus.o_Ocupado), 32'd0);
    @(negedge clk);
    chk("listo_pulso", 32'(bus.o_Listo), 32'd0);
  endtask

  task automatic quieto(input int ciclos, input string tag);
    for (int i = 0; i < ciclos; i++) begin
      @(negedge clk);
      chk({tag, "_listo"}, 32'(bus.o_Listo), 32'd0);
      chk({tag, "_ocupado"}, 32'(bus.o_Ocupado), 32'd0);
    end
  endtask

  initial begin
    int n, t_prev, v;
    bus.i_Start   = 1'b0;
    bus.i_Binario = '0;
    esp_dig       = '0;
    rst           = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ocupado", 32'(bus.o_Ocupado), 32'd0);
    chk("rst_listo", 32'(bus.o_Listo), 32'd0);
    chk("rst_desborde", 32'(bus.o_Desborde), 32'd0);
    chk("rst_digitos", 32'(digitos), 32'd0);
    rst = 1'b0;

    convertir(9751, 0, 0);
    convertir(0, 0, 0);
    convertir(9999, 0, 0);
    convertir(16383, 0, 0);
    convertir(42, 0, 0);

    // Start during conversion is ignored, only one done pulse
    convertir(1234, 5, 5678);
    quieto(20, "ignorado");

    // Start held high: 15-clock period, stable digits between pulses
    @(negedge clk);
    bus.i_Start   = 1'b1;
    bus.i_Binario = 14'd305;
    n = 0;
    while (!bus.o_Listo && n < 40) begin @(negedge clk); n++; end
    chk("continuo_primero", 32'(n < 40), 32'd1);
    esp_dig = modelo(305);
    chk("continuo_digitos", 32'(digitos), 32'(esp_dig));
    t_prev = n;
    for (int p = 0; p < 2; p++) begin
      @(negedge clk); n++;
      while (!bus.o_Listo && n < t_prev + 40) begin
        chk("continuo_estable", 32'(digitos), 32'(esp_dig));
        @(negedge clk); n++;
      end
      chk("continuo_periodo", 32'(n - t_prev), 32'd15);
      chk("continuo_digitos", 32'(digitos), 32'(esp_dig));
      t_prev = n;
    end
    bus.i_Start = 1'b0;
    quieto(3, "continuo_fin");

    // Asynchronous reset in the middle of a conversion
    convertir(9751, 0, 0);
    @(negedge clk);
    bus.i_Start   = 1'b1;
    bus.i_Binario = 14'd1111;
    @(negedge clk);
    bus.i_Start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstasinc_ocupado", 32'(bus.o_Ocupado), 32'd0);
    chk("rstasinc_listo", 32'(bus.o_Listo), 32'd0);
    chk("rstasinc_desborde", 32'(bus.o_Desborde), 32'd0);
    chk("rstasinc_digitos", 32'(digitos), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    esp_dig = '0;
    quieto(20, "tras_rst");
    chk("tras_rst_digitos", 32'(digitos), 32'd0);
    convertir(8, 0, 0);

    // Randomized values, biased towards the saturation boundary
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 0) v = int'($urandom_range(9990, 10010));
      else            v = int'($urandom_range(0, 16383));
      convertir(v, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
